divider_seq: RTL and testbench

//   Sequential radix-2 restoring divider. It is the inverse of the team's

---
 rtl/divider_seq.sv | 126 ++++++++++++
 tb/tb_divider_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Sequential radix-2 restoring divider: 2W-bit dividend / W-bit divisor.
// It produces one quotient bit per clock and uses valid/ready handshakes on input and output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready high when not in reset
// CALC  | shifting/subtracting, one quotient bit per edge, cnt counts down
// DONE  | result valid and held until out_ready
module divider_seq #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     quotient,
  output logic [W-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_d;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_quot;
  logic [W-1:0]    r_remo;
  logic            r_dbz;
  logic            r_ovf;

  logic [W-1:0]    w_hi;
  logic [W-1:0]    w_lo;
  logic [W:0]      w_t;
  logic            w_ge;
  logic [W-1:0]    w_r_next;
  logic [W-1:0]    w_q_next;

  assign w_hi = dividend[2*W-1:W];
  assign w_lo = dividend[W-1:0];

  // One restoring step. Because R < D is kept invariant, the trial value
  // fits W+1 bits and the difference always fits back into W bits.
  assign w_t      = {r_rem, r_q[W-1]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_r_next = w_ge ? (w_t[W-1:0] - r_d) : w_t[W-1:0];
  assign w_q_next = {r_q[W-2:0], w_ge};

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

  // Control FSM and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              r_dbz   <= 1'b1;
              r_ovf   <= 1'b0;
              r_quot  <= '1;
              r_remo  <= w_lo;
              r_state <= S_DONE;
            end else if (w_hi >= divisor) begin
              r_dbz   <= 1'b0;
              r_ovf   <= 1'b1;
              r_quot  <= '1;
              r_remo  <= w_lo;
              r_state <= S_DONE;
            end else begin
              r_rem   <= w_hi;
              r_q     <= w_lo;
              r_d     <= divisor;
              r_cnt   <= CW'(W - 1);
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_r_next;
          r_q   <= w_q_next;
          if (r_cnt == '0) begin
            r_quot  <= w_q_next;
            r_remo  <= w_r_next;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// Directed and exhaustive bench for divider_seq (W=4).
module tb_divider_seq;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int total;
  int bad;

  divider_seq #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and wait for the accept edge; returns 0 on timeout.
  task automatic start_op(input logic [2*W-1:0] n, input logic [W-1:0] d, output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (in_ready) begin
      dividend = n;
      divisor  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Count edges from the accept edge (counted as 1) until out_valid is seen.
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!out_valid && edges < 50) begin
      tick();
      edges++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    total++;
    if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: q=%0d r=%0d dbz=%b ovf=%b want all 0", quotient, remainder, div_by_zero, overflow);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    start_op(8'd100, 4'd7, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != 5) begin
      bad++;
      $display("FAIL basic_latency: accepted=%b edges=%0d want 1 5", ok, lat);
    end
    total++;
    if (quotient !== 4'd14 || remainder !== 4'd2 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b ovf=%b want 14 2 0 0", quotient, remainder, div_by_zero, overflow);
    end
    release_result();
  endtask

  task automatic test_max_fit();
    bit ok;
    int lat;
    start_op(8'd225, 4'd15, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != 5 || quotient !== 4'd15 || remainder !== 4'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL max_fit_225_15: edges=%0d q=%0d r=%0d ovf=%b want 5 15 0 0", lat, quotient, remainder, overflow);
    end
    release_result();
    start_op(8'd14, 4'd15, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != 5 || quotient !== 4'd0 || remainder !== 4'd14 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL max_fit_14_15: edges=%0d q=%0d r=%0d ovf=%b want 5 0 14 0", lat, quotient, remainder, overflow);
    end
    release_result();
  endtask

  task automatic test_exceptions();
    bit ok;
    int lat;
    start_op(8'd37, 4'd0, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != 1) begin
      bad++;
      $display("FAIL dbz_latency: edges=%0d want 1", lat);
    end
    total++;
    if (div_by_zero !== 1'b1 || overflow !== 1'b0 || quotient !== 4'hF || remainder !== 4'd5) begin
      bad++;
      $display("FAIL dbz_result: dbz=%b ovf=%b q=%0h r=%0d want 1 0 f 5", div_by_zero, overflow, quotient, remainder);
    end
    release_result();
    start_op(8'd240, 4'd15, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != 1 || overflow !== 1'b1 || div_by_zero !== 1'b0 || quotient !== 4'hF || remainder !== 4'd0) begin
      bad++;
      $display("FAIL ovf_result: edges=%0d ovf=%b dbz=%b q=%0h r=%0d want 1 1 0 f 0", lat, overflow, div_by_zero, quotient, remainder);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    int errs;
    start_op(8'd100, 4'd7, ok);
    wait_valid(lat);
    dividend = 8'd9;
    divisor  = 4'd3;
    in_valid = 1'b1;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 4'd14 || remainder !== 4'd2) errs++;
    end
    total++;
    if (!ok || errs != 0) begin
      bad++;
      $display("FAIL backpressure_hold: bad_cycles=%0d last ov=%b ir=%b q=%0d r=%0d want 0 1 0 14 2", errs, out_valid, in_ready, quotient, remainder);
    end
    in_valid = 1'b0;
    release_result();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 4'd14) begin
      bad++;
      $display("FAIL backpressure_release: ov=%b ir=%b q=%0d want 0 1 14", out_valid, in_ready, quotient);
    end
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int lat;
    int seen;
    start_op(8'd100, 4'd7, ok);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    total++;
    if (!ok || seen != 0) begin
      bad++;
      $display("FAIL reset_mid_valid: bad_cycles=%0d want 0", seen);
    end
    total++;
    if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_out: q=%0d r=%0d dbz=%b ovf=%b want all 0", quotient, remainder, div_by_zero, overflow);
    end
    start_op(8'd100, 4'd7, ok);
    wait_valid(lat);
    total++;
    if (!ok || lat != 5 || quotient !== 4'd14 || remainder !== 4'd2) begin
      bad++;
      $display("FAIL reset_mid_recover: edges=%0d q=%0d r=%0d want 5 14 2", lat, quotient, remainder);
    end
    release_result();
  endtask

  task automatic test_exhaustive();
    bit ok;
    int lat;
    int n;
    int exp_q;
    int exp_r;
    int k;
    for (int d = 1; d < 16; d++) begin
      for (n = 0; n < d * 16; n++) begin
        exp_q = n / d;
        exp_r = n % d;
        start_op(8'(n), 4'(d), ok);
        wait_valid(lat);
        total++;
        if (!ok || lat != 5 || int'(quotient) != exp_q || int'(remainder) != exp_r ||
            div_by_zero !== 1'b0 || overflow !== 1'b0) begin
          bad++;
          $display("FAIL exh_%0d_%0d: edges=%0d q=%0d r=%0d dbz=%b ovf=%b want 5 %0d %0d 0 0",
                   n, d, lat, quotient, remainder, div_by_zero, overflow, exp_q, exp_r);
        end
        total++;
        if (int'(quotient) * d + int'(remainder) != n || int'(remainder) >= d) begin
          bad++;
          $display("FAIL exh_ident_%0d_%0d: q*d+r=%0d r=%0d want %0d and r<%0d",
                   n, d, int'(quotient) * d + int'(remainder), remainder, n, d);
        end
        k = 0;
        do begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          k++;
        end while (out_ready == 1'b0 && k < 20);
        if (out_ready == 1'b0) begin
          out_ready = 1'b1;
          tick();
        end
        out_ready = 1'b0;
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_max_fit();
    test_exceptions();
    test_backpressure();
    test_reset_mid_op();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
